// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel push-button front end.
// Each channel has a polarity-corrected input flop and a SYNC_STAGES-deep
// synchroniser, followed by a stability-count debouncer. A level change is
// reported as a registered one-cycle press or release pulse.
// Optional auto-repeat of press pulses while a button is held is compiled in
// when the macro BTN_AUTOREPEAT_EN is defined. The ports are the same in both builds.
module btn_conditioner #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_LIMIT      = 16,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    localparam logic [N_CH-1:0]  POL    = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_LIMIT - 1);

    // Reject illegal parameter combinations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("btn_conditioner: SYNC_STAGES must be 2..4");
    end
    if (DB_LIMIT < 2 || (CNT_W < 31 && DB_LIMIT > (1 << CNT_W) - 1)) begin : g_bad_db
        $error("btn_conditioner: DB_LIMIT out of range for CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
        $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_CH-1:0]  pin_q;
    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  s;
    logic [CNT_W-1:0] cnt      [N_CH];
    logic [CNT_W-1:0] cnt_next [N_CH];
    logic [N_CH-1:0]  lvl;
    logic [N_CH-1:0]  lvl_next;
    logic [N_CH-1:0]  rep_hit;

    // The input flop captures the polarity-corrected pin. The synchroniser chain follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            pin_q     <= btn_raw ^ POL;
            sync_q[0] <= pin_q;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce next state. Any cycle that agrees with the current level restarts the count.
    always_comb begin
        lvl_next = lvl;
        for (int c = 0; c < N_CH; c++) begin
            cnt_next[c] = cnt[c];
            if (s[c] == lvl[c]) begin
                cnt_next[c] = '0;
            end else if (cnt[c] == DB_MAX) begin
                lvl_next[c] = s[c];
                cnt_next[c] = '0;
            end else begin
                cnt_next[c] = cnt[c] + CNT_W'(1);
            end
        end
    end

    // Debounced level and counters. The edge pulses are registered in the same cycle as the level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl         <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
        end else begin
            lvl         <= lvl_next;
            btn_press   <= (lvl_next & ~lvl) | rep_hit;
            btn_release <= lvl & ~lvl_next;
            for (int c = 0; c < N_CH; c++) cnt[c] <= cnt_next[c];
        end
    end

    assign btn_level = lvl;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rc      [N_CH];
    logic [CNT_W-1:0] rc_next [N_CH];
    logic [N_CH-1:0]  first;
    logic [N_CH-1:0]  first_next;

    // Repeat timing: the first gap uses the long delay and later gaps use the period.
    // A release seen in the same cycle takes priority over a repeat.
    always_comb begin
        rep_hit    = '0;
        first_next = first;
        for (int c = 0; c < N_CH; c++) begin
            rc_next[c] = rc[c];
            if (!lvl_next[c]) begin
                rc_next[c]    = '0;
                first_next[c] = 1'b0;
            end else if (!lvl[c]) begin
                rc_next[c]    = '0;
                first_next[c] = 1'b1;
            end else if ((first[c] && rc[c] == RD_MAX) || (!first[c] && rc[c] == RP_MAX)) begin
                rep_hit[c]    = 1'b1;
                rc_next[c]    = '0;
                first_next[c] = 1'b0;
            end else begin
                rc_next[c] = rc[c] + CNT_W'(1);
            end
        end
    end

    // Repeat counter and first-repeat flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first <= '0;
            for (int c = 0; c < N_CH; c++) rc[c] <= '0;
        end else begin
            first <= first_next;
            for (int c = 0; c < N_CH; c++) rc[c] <= rc_next[c];
        end
    end
`else
    assign rep_hit = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner. Instance dut_a is active-high and dut_b is active-low.
// Both use DB_LIMIT=4 and SYNC_STAGES=2. Define BTN_AUTOREPEAT_EN to cover the repeat build.
module tb_btn_conditioner;

  localparam int NCH   = 4;
  localparam int SS    = 2;
  localparam int DB    = 4;
  localparam int RD    = 10;
  localparam int RP    = 3;
  localparam int D     = SS + 1;
  localparam int DEPTH = D + DB;

  logic clk;
  logic rst;
  logic [NCH-1:0] raw_a, raw_b;
  logic [NCH-1:0] level_a, press_a, release_a;
  logic [NCH-1:0] level_b, press_b, release_b;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  btn_conditioner #(
    .N_CH(NCH), .SYNC_STAGES(SS), .DB_LIMIT(DB), .CNT_W(16), .ACTIVE_LOW(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(raw_a),
    .btn_level(level_a), .btn_press(press_a), .btn_release(release_a)
  );

  btn_conditioner #(
    .N_CH(NCH), .SYNC_STAGES(SS), .DB_LIMIT(DB), .CNT_W(16), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_raw(raw_b),
    .btn_level(level_b), .btn_press(press_b), .btn_release(release_b)
  );

  // ---------------- reference model ----------------
  // A channel's level flips once the last DB samples seen by the debouncer all differ from it.
  // Those are the pressed values taken D to D+DB-1 edges ago.
  // With auto-repeat, extra presses fall at ages RD, RD+RP, RD+2*RP, ... counted from the accepted press.
  logic [NCH-1:0] hist [2][DEPTH];
  logic [NCH-1:0] m_lvl [2];
  logic [NCH-1:0] m_press [2];
  logic [NCH-1:0] m_rel [2];
  int age [2][NCH];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) hist[k][i] = '0;
      m_lvl[k] = '0;
      m_press[k] = '0;
      m_rel[k] = '0;
      for (int c = 0; c < NCH; c++) age[k][c] = 0;
    end
  endfunction

  function automatic void model_edge(input int k, input logic [NCH-1:0] p);
    for (int i = 0; i < DEPTH - 1; i++) hist[k][i] = hist[k][i+1];
    hist[k][DEPTH-1] = p;
    m_press[k] = '0;
    m_rel[k] = '0;
    for (int c = 0; c < NCH; c++) begin
      logic flip;
      flip = 1'b1;
      for (int w = 0; w < DB; w++) if (hist[k][w][c] == m_lvl[k][c]) flip = 1'b0;
      if (flip) begin
        m_lvl[k][c] = ~m_lvl[k][c];
        if (m_lvl[k][c]) begin
          m_press[k][c] = 1'b1;
          age[k][c] = 0;
        end else begin
          m_rel[k][c] = 1'b1;
        end
      end else if (m_lvl[k][c]) begin
        age[k][c]++;
`ifdef BTN_AUTOREPEAT_EN
        if (age[k][c] >= RD && ((age[k][c] - RD) % RP) == 0) m_press[k][c] = 1'b1;
`endif
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual %b required %b", name, $time, act, exp);
    end
  endtask

  // One clock edge: advance the model, then compare both DUTs 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_edge(0, raw_a);
      model_edge(1, ~raw_b);
    end
    #1;
    check("model level_a", level_a, m_lvl[0]);
    check("model press_a", press_a, m_press[0]);
    check("model release_a", release_a, m_rel[0]);
    check("model level_b", level_b, m_lvl[1]);
    check("model press_b", press_b, m_press[1]);
    check("model release_b", release_b, m_rel[1]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NCH-1:0] raw;
    int             hold;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] pm;
    logic [NCH-1:0] rm;
    int             np;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [NCH-1:0] pm, rm;
    int np;

    tbl[0] = '{raw: 4'b0001, hold: 8, lvl: 4'b0001, pm: 4'b0001, rm: 4'b0000, np: 1};
    tbl[1] = '{raw: 4'b0110, hold: 8, lvl: 4'b0110, pm: 4'b0110, rm: 4'b0001, np: 2};
    tbl[2] = '{raw: 4'b1000, hold: 8, lvl: 4'b1000, pm: 4'b1000, rm: 4'b0110, np: 1};
    tbl[3] = '{raw: 4'b0111, hold: 8, lvl: 4'b0111, pm: 4'b0111, rm: 4'b1000, np: 3};
    tbl[4] = '{raw: 4'b0000, hold: 8, lvl: 4'b0000, pm: 4'b0000, rm: 4'b0111, np: 0};
    tbl[5] = '{raw: 4'b0010, hold: 3, lvl: 4'b0000, pm: 4'b0000, rm: 4'b0000, np: 0};
    tbl[6] = '{raw: 4'b0000, hold: 8, lvl: 4'b0000, pm: 4'b0000, rm: 4'b0000, np: 0};
    tbl[7] = '{raw: 4'b0010, hold: 4, lvl: 4'b0000, pm: 4'b0000, rm: 4'b0000, np: 0};
    tbl[8] = '{raw: 4'b0000, hold: 8, lvl: 4'b0000, pm: 4'b0010, rm: 4'b0010, np: 1};

    // Reset state
    model_reset();
    rst = 1'b1;
    raw_a = 4'b0000;
    raw_b = 4'b1111;
    #2;
    check("reset level_a", level_a, 4'b0000);
    check("reset press_a", press_a, 4'b0000);
    check("reset release_a", release_a, 4'b0000);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Table-driven vectors on dut_a
    for (int v = 0; v < 9; v++) begin
      raw_a = tbl[v].raw;
      pm = '0;
      rm = '0;
      np = 0;
      for (int e = 0; e < tbl[v].hold; e++) begin
        step();
        pm |= press_a;
        rm |= release_a;
        np += $countones(press_a);
      end
      check($sformatf("tbl%0d level", v), level_a, tbl[v].lvl);
      check($sformatf("tbl%0d press mask", v), pm, tbl[v].pm);
      check($sformatf("tbl%0d release mask", v), rm, tbl[v].rm);
      check($sformatf("tbl%0d press count", v), 4'(np), 4'(tbl[v].np));
    end

    // Clean press: pulse exactly at edge 6, level from edge 6
    raw_a = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("clean press e%0d", e), press_a, (e == 6) ? 4'b0001 : 4'b0000);
      check($sformatf("clean level e%0d", e), level_a, (e >= 6) ? 4'b0001 : 4'b0000);
    end
    raw_a = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("clean release e%0d", e), release_a, (e == 6) ? 4'b0001 : 4'b0000);
      check($sformatf("clean nopress e%0d", e), press_a, 4'b0000);
      check($sformatf("clean rlevel e%0d", e), level_a, (e < 6) ? 4'b0001 : 4'b0000);
    end

    // Active-low simultaneous press on dut_b
    raw_b = 4'b0101;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("actlow press e%0d", e), press_b, (e == 6) ? 4'b1010 : 4'b0000);
    end
    check("actlow level", level_b, 4'b1010);
    raw_b = 4'b1111;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("actlow release e%0d", e), release_b, (e == 6) ? 4'b1010 : 4'b0000);
    end
    check("actlow level off", level_b, 4'b0000);

    // Reset while the press pulse of channel 2 is high
    raw_a = 4'b0100;
    for (int e = 0; e < 7; e++) step();
    check("pre-reset press", press_a, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("async rst level", level_a, 4'b0000);
    check("async rst press", press_a, 4'b0000);
    check("async rst release", release_a, 4'b0000);
    model_reset();
    step();
    step();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("post-rst press e%0d", e), press_a, (e == 6) ? 4'b0100 : 4'b0000);
    end
    raw_a = 4'b0000;
    for (int e = 0; e < 8; e++) step();

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat on channel 3: press at 6, repeats at 16, 19, 22, 25, 28
    raw_a = 4'b1000;
    for (int e = 0; e < 30; e++) begin
      step();
      check($sformatf("repeat press e%0d", e), press_a,
            (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 || e == 28) ? 4'b1000 : 4'b0000);
    end
    raw_a = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("repeat tail press e%0d", e), press_a,
            (e == 1 || e == 4) ? 4'b1000 : 4'b0000);
      check($sformatf("repeat release e%0d", e), release_a, (e == 6) ? 4'b1000 : 4'b0000);
    end
`endif

    // Randomized stimulus against the model
    for (int n = 0; n < 300; n++) begin
      int hold;
      raw_a = 4'($urandom_range(0, 15));
      raw_b = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      for (int e = 0; e < hold; e++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Multi-channel push-button front end for the game logic.
- Per channel, in order:
  - synchronises the raw pin;
  - debounces it with a stability counter;
  - emits single-cycle press and release pulses.
- Replaces the one-pulse-per-press stage and the separate synchroniser, so round/advance logic gets clean, glitch-free one-cycle events from any number of buttons.

Parameters:
- N_CH, 4, number of independent button channels.
- SYNC_STAGES, 2, flip-flop synchroniser depth (legal 2..4).
- DB_LIMIT, 16, consecutive stable synchronised cycles required to accept a level change (legal 2..2^CNT_W-1).
- CNT_W, 16, debounce/repeat counter width.
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inverted before synchroniser.
- REPEAT_DELAY, 1000, cycles from accepted press to first repeat pulse (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 200, cycles between subsequent repeat pulses (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  N_CH  raw asynchronous button pins.
- btn_level  out  N_CH  debounced pressed level, 1 = pressed.
- btn_press  out  N_CH  one-cycle pulse on accepted press (and on repeats when enabled).
- btn_release  out  N_CH  one-cycle pulse on accepted release.

Behaviour:
- Channels are fully independent; no cross-channel arbitration. Simultaneous presses on several channels pulse in the same cycle.
- Polarity: p = btn_raw ^ {N_CH{ACTIVE_LOW}}. p feeds a SYNC_STAGES-deep shift chain; s = last stage.
- Debounce, per channel:
  - Counter cnt and stable level lvl.
  - If s == lvl: cnt <= 0.
  - Else if cnt == DB_LIMIT-1: lvl <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s to lvl before the limit restarts the count. Bounces shorter than DB_LIMIT cycles produce no event.
- Events are registered, asserted in the same cycle lvl changes, high for exactly one cycle:
  - btn_press = lvl rising.
  - btn_release = lvl falling.
- btn_level = lvl.
- Latency: if btn_raw changes and holds from before edge 0, lvl, btn_level and the pulse update at edge SYNC_STAGES+DB_LIMIT.
- Pulses for the same channel are never back-to-back: at least DB_LIMIT cycles separate press and release.
- Reset: all sync stages, cnt, lvl, btn_level, btn_press, btn_release <= 0 immediately and asynchronously.
- Reset mid-press:
  - Pulses abort.
  - After rst deasserts with a button still held, the channel treats it as a new press: btn_press fires at edge SYNC_STAGES+DB_LIMIT after the first clock edge following release of rst.
- Counter saturation cannot occur: the count never exceeds DB_LIMIT-1.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Per channel repeat counter rc (CNT_W bits) and first-flag.
  - On accepted press: rc <= 0, first <= 1.
  - While lvl == 1: rc increments each cycle.
  - When rc reaches REPEAT_DELAY-1 (first==1) or REPEAT_PERIOD-1 (first==0): btn_press pulses one cycle, rc <= 0, first <= 0.
  - Release or reset clears rc and first immediately; no repeat pulse in the release cycle.
- Undefined:
  - No repeat logic is synthesised; REPEAT_* parameters are ignored.
  - btn_press fires once per accepted press only.
- Ports are identical in both builds.

Test Plan:
- N_CH=4, SYNC_STAGES=2, DB_LIMIT=4 for all scenarios; repeat scenario additionally REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btn_raw[0] 0->1 held 20 cycles -> btn_press[0] high exactly 1 cycle at edge 6, btn_level[0]=1 from edge 6; no pulses on channels 1-3.
- Bounce reject: btn_raw[1] toggles 1,0,1,0 each 2 cycles then 0 -> no btn_press[1]/btn_release[1], btn_level[1] stays 0. Then hold 1 for 4+ cycles -> single press pulse.
- Release: channel 0 pressed then btn_raw[0] 1->0 held -> btn_release[0] one cycle 6 edges later, btn_level[0]=0; btn_press[0] stays 0.
- Simultaneous + polarity: ACTIVE_LOW=1, btn_raw 4'b1111 -> 4'b0101 held -> btn_press = 4'b1010 in one cycle, btn_level = 4'b1010.
- Reset mid-operation: rst pulsed while btn_raw[2]=1 and btn_level[2]=1 -> all outputs 0 asynchronously. After deassert, hold 1 -> btn_press[2] fires at edge 6 after the first post-reset edge.
- BTN_AUTOREPEAT_EN: hold btn_raw[3]=1 -> press at edge 6, repeats at edges 16, 19, 22. Release -> repeats stop, btn_release[3] fires once.
